// File: rtl/rvfi_commit_serializer.sv
// Dual-lane retire packets merged into a single in-order RVFI commit stream through a circular FIFO.
// Optional same-cycle bypass of an empty FIFO: define RVFI_SER_BYPASS_EN.
module rvfi_commit_serializer #(
    parameter int DEPTH   = 8,
    parameter int ORDER_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lane0_valid,
    input  logic [173:0]       lane0_pkt,
    input  logic               lane1_valid,
    input  logic [173:0]       lane1_pkt,
    output logic               in_ready,
    output logic               out_valid,
    output logic [173:0]       out_pkt,
    output logic [ORDER_W-1:0] out_order,
    input  logic               out_ready,
    output logic               halt,
    output logic               proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] SELF_LOOP_JAL = 32'h0000006F;

    logic [173:0]       mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [PTR_W-1:0]   wptr_p1;
    logic [CNT_W-1:0]   count;
    logic [ORDER_W-1:0] order;
    logic               halt_q;
    logic               proto_err_q;

    logic               fifo_nonempty;
    logic               do_bypass;
    logic               byp_take;
    logic               pop_fifo;
    logic               commit;
    logic [31:0]        head_inst;
    logic               wr_a_en;
    logic               wr_b_en;
    logic [173:0]       wr_a_data;
    logic [1:0]         n_push;

    assign fifo_nonempty = (count != '0);
    assign in_ready      = (count <= CNT_W'(DEPTH - 2));
    assign wptr_p1       = wptr + PTR_W'(1);

    always_comb begin
        do_bypass = 1'b0;
`ifdef RVFI_SER_BYPASS_EN
        do_bypass = !fifo_nonempty && lane0_valid && in_ready;
`endif
    end

    assign out_valid = fifo_nonempty | do_bypass;
    assign out_pkt   = do_bypass ? lane0_pkt : mem[rptr];
    assign out_order = order;
    assign head_inst = out_pkt[141:110];
    assign halt      = halt_q;
    assign proto_err = proto_err_q;

    assign byp_take  = do_bypass & out_ready;
    assign pop_fifo  = fifo_nonempty & out_ready;
    assign commit    = out_valid & out_ready;

    // Slot A lands at wptr, slot B at wptr+1; a consumed bypass frees slot A for lane1.
    always_comb begin
        wr_a_en   = 1'b0;
        wr_b_en   = 1'b0;
        wr_a_data = lane0_pkt;
        if (byp_take) begin
            wr_a_en   = lane1_valid;
            wr_a_data = lane1_pkt;
        end else if (in_ready && lane0_valid) begin
            wr_a_en = 1'b1;
            wr_b_en = lane1_valid;
        end
    end

    assign n_push = {1'b0, wr_a_en} + {1'b0, wr_b_en};

    always_ff @(posedge clk) begin
        if (wr_a_en) begin
            mem[wptr] <= wr_a_data;
        end
        if (wr_b_en) begin
            mem[wptr_p1] <= lane1_pkt;
        end
    end

    // Pointers wrap naturally through PTR_W truncation since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            order       <= '0;
            halt_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            wptr  <= wptr + PTR_W'(n_push);
            rptr  <= rptr + PTR_W'(pop_fifo);
            count <= count + CNT_W'(n_push) - CNT_W'(pop_fifo);
            if (commit) begin
                order <= order + ORDER_W'(1);
            end
            if (commit && head_inst == SELF_LOOP_JAL) begin
                halt_q <= 1'b1;
            end
            if (lane1_valid && !lane0_valid) begin
                proto_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Randomized self-checking bench for rvfi_commit_serializer against a queue-based reference model.
module tb_rvfi_commit_serializer;

    localparam int DEPTH = 8;

    logic         clk;
    logic         rst_n;
    logic         lane0_valid;
    logic [173:0] lane0_pkt;
    logic         lane1_valid;
    logic [173:0] lane1_pkt;
    logic         in_ready;
    logic         out_valid;
    logic [173:0] out_pkt;
    logic [63:0]  out_order;
    logic         out_ready;
    logic         halt;
    logic         proto_err;

    rvfi_commit_serializer #(.DEPTH(DEPTH), .ORDER_W(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lane0_valid(lane0_valid),
        .lane0_pkt(lane0_pkt),
        .lane1_valid(lane1_valid),
        .lane1_pkt(lane1_pkt),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_pkt(out_pkt),
        .out_order(out_order),
        .out_ready(out_ready),
        .halt(halt),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [173:0] mq[$];
    logic [63:0]  m_order;
    logic         m_halt;
    logic         m_perr;
    logic [31:0]  next_pc;

    task automatic checkOutput(input string tag, input logic [173:0] observed, input logic [173:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [173:0] mk_pkt(input logic [31:0] pc, input logic [31:0] inst);
        logic [173:0] p;
        logic [31:0]  r;
        p[173:142] = pc;
        p[141:110] = inst;
        r = $urandom;
        p[109:104] = r[5:0];
        p[103:72]  = $urandom;
        r = $urandom;
        p[71:64]   = r[7:0];
        p[63:32]   = $urandom;
        p[31:0]    = $urandom;
        return p;
    endfunction

    task automatic clearModel();
        mq.delete();
        m_order = '0;
        m_halt  = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n       = 1'b0;
        lane0_valid = 1'b0;
        lane1_valid = 1'b0;
        lane0_pkt   = '0;
        lane1_pkt   = '0;
        out_ready   = 1'b0;
        #1;
        checkOutput("rst_out_valid", 174'(out_valid), 174'(1'b0));
        checkOutput("rst_in_ready", 174'(in_ready), 174'(1'b1));
        clearModel();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, check DUT outputs against the model at the falling edge, then advance the model.
    task automatic applyStimulus(input logic v0, input logic [173:0] p0, input logic v1,
                                 input logic [173:0] p1, input logic rdy, output logic accepted);
        logic         exp_ready;
        logic         exp_valid;
        logic         byp;
        logic         take;
        logic [173:0] head;
        lane0_valid = v0;
        lane0_pkt   = p0;
        lane1_valid = v1;
        lane1_pkt   = p1;
        out_ready   = rdy;
        @(negedge clk);
        byp = 1'b0;
`ifdef RVFI_SER_BYPASS_EN
        byp = (mq.size() == 0) && v0;
`endif
        exp_ready = (DEPTH - mq.size()) >= 2;
        exp_valid = (mq.size() != 0) || byp;
        head      = byp ? p0 : ((mq.size() != 0) ? mq[0] : '0);
        checkOutput("in_ready", 174'(in_ready), 174'(exp_ready));
        checkOutput("out_valid", 174'(out_valid), 174'(exp_valid));
        if (exp_valid) begin
            checkOutput("out_pkt", out_pkt, head);
            checkOutput("out_order", 174'(out_order), 174'(m_order));
        end
        checkOutput("halt", 174'(halt), 174'(m_halt));
        checkOutput("proto_err", 174'(proto_err), 174'(m_perr));
        take = exp_valid && rdy;
        if (take) begin
            m_order = m_order + 64'd1;
            if (head[141:110] == 32'h0000006F) m_halt = 1'b1;
            if (!byp) void'(mq.pop_front());
        end
        if (v1 && !v0) m_perr = 1'b1;
        accepted = exp_ready && v0;
        if (accepted) begin
            if (!(byp && take)) mq.push_back(p0);
            if (v1) mq.push_back(p1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles, input logic rdy);
        logic acc;
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, 1'b0, '0, rdy, acc);
    endtask

    // Upstream holds a rejected pair until it is accepted; lane1 never fires without lane0 here.
    task automatic runTraffic(input int cycles, input bit random_mode);
        logic         v0;
        logic         v1;
        logic         rdy;
        logic         acc;
        logic [173:0] p0;
        logic [173:0] p1;
        v0  = 1'b0;
        v1  = 1'b0;
        p0  = '0;
        p1  = '0;
        acc = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (acc || !v0) begin
                v0 = random_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                v1 = v0 && (random_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
                p0 = mk_pkt(next_pc, $urandom);
                p1 = mk_pkt(next_pc + 32'd4, $urandom);
                next_pc = next_pc + 32'd8;
            end
            rdy = random_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            applyStimulus(v0, p0, v1, p1, rdy, acc);
        end
    endtask

    initial begin
        logic         acc;
        logic [173:0] p0;
        logic [173:0] p1;
        rst_n       = 1'b0;
        lane0_valid = 1'b0;
        lane1_valid = 1'b0;
        lane0_pkt   = '0;
        lane1_pkt   = '0;
        out_ready   = 1'b0;
        next_pc     = 32'h0001_0000;
        clearModel();

        // Single packet latency
        doReset();
        applyStimulus(1'b1, mk_pkt(32'h4000_0000, 32'h00A0_0093), 1'b0, '0, 1'b1, acc);
        checkOutput("t1_valid", 174'(out_valid), 174'(1'b1));
        checkOutput("t1_pc", 174'(out_pkt[173:142]), 174'(32'h4000_0000));
        checkOutput("t1_order", 174'(out_order), '0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, acc);
        checkOutput("t1_empty", 174'(out_valid), 174'(1'b0));

        // Fill to full, hold a pair, then drain
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, mk_pkt(next_pc, $urandom), 1'b1, mk_pkt(next_pc + 32'd4, $urandom), 1'b0, acc);
            next_pc = next_pc + 32'd8;
        end
        checkOutput("t2_full_ready", 174'(in_ready), '0);
        p0 = mk_pkt(next_pc, $urandom);
        p1 = mk_pkt(next_pc + 32'd4, $urandom);
        next_pc = next_pc + 32'd8;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, p0, 1'b1, p1, 1'b0, acc);
        checkOutput("t2_held", 174'(acc), '0);
        for (int i = 0; i < 14; i++) begin
            if (!acc) applyStimulus(1'b1, p0, 1'b1, p1, 1'b1, acc);
            else idle(1, 1'b1);
        end
        checkOutput("t2_drained", 174'(out_valid), '0);

        // Saturating dual push across pointer wrap, then random traffic
        doReset();
        runTraffic(40, 1'b0);
        idle(DEPTH + 2, 1'b1);
        checkOutput("t3_drained", 174'(out_valid), '0);
        runTraffic(400, 1'b1);
        idle(DEPTH + 2, 1'b1);

        // Halt on self-loop jump
        doReset();
        applyStimulus(1'b1, mk_pkt(32'h0000_2000, 32'h0000_006F), 1'b0, '0, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, acc);
        checkOutput("t4_halt", 174'(halt), 174'(1'b1));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, mk_pkt(next_pc, 32'h0000_0013), 1'b0, '0, 1'b1, acc);
            next_pc = next_pc + 32'd4;
        end
        idle(1, 1'b1);
        checkOutput("t4_halt_sticky", 174'(halt), 174'(1'b1));
        doReset();
        checkOutput("t4_halt_cleared", 174'(halt), '0);

        // Lane1 without lane0
        doReset();
        applyStimulus(1'b0, '0, 1'b1, mk_pkt(32'h0000_3000, $urandom), 1'b1, acc);
        checkOutput("t5_proto_err", 174'(proto_err), 174'(1'b1));
        checkOutput("t5_nothing_queued", 174'(out_valid), '0);
        idle(2, 1'b1);
        checkOutput("t5_proto_sticky", 174'(proto_err), 174'(1'b1));

        // Asynchronous reset mid-burst
        doReset();
        applyStimulus(1'b1, mk_pkt(32'h0000_4000, $urandom), 1'b1, mk_pkt(32'h0000_4004, $urandom), 1'b0, acc);
        applyStimulus(1'b1, mk_pkt(32'h0000_4008, $urandom), 1'b1, mk_pkt(32'h0000_400C, $urandom), 1'b0, acc);
        applyStimulus(1'b1, mk_pkt(32'h0000_4010, $urandom), 1'b0, '0, 1'b0, acc);
        checkOutput("t6_buffered", 174'(out_valid), 174'(1'b1));
        #2;
        rst_n       = 1'b0;
        lane0_valid = 1'b0;
        lane1_valid = 1'b0;
        #1;
        checkOutput("t6_async_valid", 174'(out_valid), '0);
        checkOutput("t6_async_ready", 174'(in_ready), 174'(1'b1));
        clearModel();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2, 1'b1);
        applyStimulus(1'b1, mk_pkt(32'h0000_5000, $urandom), 1'b0, '0, 1'b0, acc);
        checkOutput("t6_order", 174'(out_order), '0);
        checkOutput("t6_pc", 174'(out_pkt[173:142]), 174'(32'h0000_5000));
        idle(2, 1'b1);

`ifdef RVFI_SER_BYPASS_EN
        // Same-cycle bypass from an empty FIFO
        doReset();
        lane0_valid = 1'b1;
        lane0_pkt   = mk_pkt(32'h0000_0100, 32'h0000_0013);
        out_ready   = 1'b1;
        #1;
        checkOutput("t7_byp_valid", 174'(out_valid), 174'(1'b1));
        checkOutput("t7_byp_pc", 174'(out_pkt[173:142]), 174'(32'h0000_0100));
        applyStimulus(1'b1, lane0_pkt, 1'b0, '0, 1'b1, acc);
        checkOutput("t7_count_zero", 174'(out_valid), '0);
        idle(1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
